// File: rtl/task1_pkg.sv
// Shared types and constants for the task1 P/Q sweep checker.
// Holds the FSM state encoding and the expected {P,Q} table indexed by {A,B,C}.
package task1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VEC = 8;

    // Index 0 is {A,B,C}=000; each entry is {P,Q}.
    localparam logic [1:0] EXP_PQ [8] = '{
        2'b01, 2'b11, 2'b01, 2'b00,
        2'b10, 2'b10, 2'b00, 2'b00
    };

endpackage

// File: rtl/task1_sweep_fsm.sv
// Sweep sequencer: state register, current vector and settle counter.
// The state is exported so checkers can bind to it directly.
module task1_sweep_fsm
    import task1_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output state_t     state,
    output logic [2:0] vec,
    output logic       accept,
    output logic       check_en
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_VEC    = 3'(NUM_VEC - 1);

    state_t     state_nx;
    logic [2:0] vec_nx;
    logic [3:0] scnt;
    logic [3:0] scnt_nx;

    // start is a one-cycle request with no ready: it is taken only when the
    // sequencer sits in IDLE or DONE, and is silently dropped otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            vec   <= 3'd0;
            scnt  <= 4'd0;
        end else begin
            state <= state_nx;
            vec   <= vec_nx;
            scnt  <= scnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        vec_nx   = vec;
        scnt_nx  = scnt;
        accept   = 1'b0;
        check_en = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    vec_nx   = 3'd0;
                    scnt_nx  = SETTLE_LOAD;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (scnt == 4'd0) begin
                    state_nx = CHECK;
                end else begin
                    scnt_nx = scnt - 4'd1;
                end
            end
            CHECK: begin
                check_en = 1'b1;
                if (vec == LAST_VEC) begin
                    state_nx = DONE;
                end else begin
                    vec_nx   = vec + 3'd1;
                    scnt_nx  = SETTLE_LOAD;
                    state_nx = SETTLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/task1_sweep_checker.sv
// Drives A/B/C through all 8 vectors and scores P/Q against the task1 table.
// Optional first-failure log is enabled by defining TASK1_SWEEP_FAILLOG_EN.
module task1_sweep_checker
    import task1_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             p_in,
    input  logic             q_in,
    output logic             a_out,
    output logic             b_out,
    output logic             c_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
`ifdef TASK1_SWEEP_FAILLOG_EN
    output logic [2:0]       first_fail_vec,
    output logic [1:0]       first_fail_pq,
    output logic             fail_seen,
`endif
    output logic             all_pass
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end
    if (CNT_W < 4) begin : g_bad_cnt_w
        $error("CNT_W must be at least 4 to hold a count of 8");
    end

    state_t     state;
    logic [2:0] vec;
    logic       accept;
    logic       check_en;
    logic       match;

    task1_sweep_fsm #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .state    (state),
        .vec      (vec),
        .accept   (accept),
        .check_en (check_en)
    );

    // The vector register feeds the unit under test directly, so no decode glitches.
    assign {a_out, b_out, c_out} = vec;
    assign busy     = (state == SETTLE) || (state == CHECK);
    assign done     = (state == DONE);
    assign all_pass = done && (fail_cnt == '0);
    assign match    = ({p_in, q_in} == EXP_PQ[vec]);

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (check_en) begin
            if (match) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
        end
    end

`ifdef TASK1_SWEEP_FAILLOG_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            first_fail_vec <= 3'd0;
            first_fail_pq  <= 2'd0;
            fail_seen      <= 1'b0;
        end else if (check_en && !match && !fail_seen) begin
            first_fail_vec <= vec;
            first_fail_pq  <= {p_in, q_in};
            fail_seen      <= 1'b1;
        end
    end
`endif

endmodule
